alu_cmd_arbiter: RTL

ALU_CMD_ARBITER -- requirements
Module: alu_cmd_arbiter

---
 rtl/alu_cmd_arbiter.sv | 85 ++++++++
 1 files changed

// File: rtl/alu_cmd_arbiter.sv
// alu_cmd_arbiter: round-robin arbiter sharing one ALU controller among N_REQ requesters, one command in flight
module alu_cmd_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*12-1:0] req_cmd,
  output logic [N_REQ-1:0]    req_grant,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [31:0]         rsp_y,
  output logic                rsp_z,
  output logic                rsp_err,
  output logic [11:0]         command,
  output logic                syscall,
  input  logic                ready,
  input  logic [31:0]         y,
  input  logic                Z
);
  localparam int W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state;
  logic [W-1:0] last_grant, winner, win;
  logic [7:0] cnt;
  logic any, done;
  // nearest valid requester after last_grant wins; iterate farthest first so nearest overrides
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req_valid[(int'(last_grant) + k) % N_REQ]) begin
        win = W'((int'(last_grant) + k) % N_REQ);
        any = 1'b1;
      end
    end
  end
  // a CAS needs one extra clock before the controller result is valid
  assign done = ready && (cnt >= ((command[11:9] == 3'b111) ? 8'd2 : 8'd1));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= W'(N_REQ - 1);
      winner     <= '0;
      command    <= '0;
      req_grant  <= '0;
      rsp_valid  <= '0;
      syscall    <= 1'b0;
      rsp_y      <= '0;
      rsp_z      <= 1'b0;
      rsp_err    <= 1'b0;
      cnt        <= '0;
    end else begin
      req_grant <= '0;
      rsp_valid <= '0;
      syscall   <= 1'b0;
      case (state)
        IDLE: if (any && ready) begin
          state      <= ISSUE;
          winner     <= win;
          last_grant <= win;
          command    <= req_cmd[int'(win)*12 +: 12];
          req_grant  <= N_REQ'(1) << win;
          syscall    <= 1'b1;
        end
        ISSUE: begin
          state <= WAIT;
          cnt   <= '0;
        end
        WAIT: begin
          if (done || cnt == 8'(TIMEOUT - 1)) begin
            state     <= RESP;
            rsp_y     <= done ? y : '0;
            rsp_z     <= done ? Z : 1'b0;
            rsp_err   <= !done;
            rsp_valid <= N_REQ'(1) << winner;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
